// File: rtl/fetch_unit_ras.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency instruction memory,
// and redirects via branch, jump, or call/return through a circular return-address stack.
module fetch_unit_ras #(
    parameter int              PC_W      = 8,
    parameter int              INST_W    = 32,
    parameter int              OFFS_W    = 16,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic                            clk,
    input  logic                            counterRst,
    input  logic                            counterLd,
    input  logic                            pcSrc,
    input  logic signed [OFFS_W-1:0]        brOffset,
    input  logic                            jmp,
    input  logic [PC_W-1:0]                 jmpTarget,
    input  logic                            call,
    input  logic                            ret,
    output logic [PC_W-1:0]                 imemAddr,
    input  logic [INST_W-1:0]               imemData,
    output logic [PC_W-1:0]                 pc,
    output logic [INST_W-1:0]               inst,
    output logic                            instValid,
    output logic [PC_W-1:0]                 linkAddr,
    output logic [$clog2(RAS_DEPTH):0]      rasDepth,
    output logic                            rasOverflow,
    output logic                            rasUnderflow
);

    localparam int SP_W  = $clog2(RAS_DEPTH);
    localparam int DEP_W = SP_W + 1;

    logic [PC_W-1:0] ras_mem [RAS_DEPTH];
    logic [SP_W-1:0] top;
    logic [PC_W-1:0] next_pc;
    logic [PC_W-1:0] br_target;
    logic            do_push;
    logic            do_pop;
    logic            ras_empty;
    logic            ras_full;

    assign linkAddr  = pc + PC_W'(1);
    assign inst      = imemData;
    assign br_target = linkAddr + PC_W'(brOffset);
    assign ras_empty = (rasDepth == '0);
    assign ras_full  = (rasDepth == DEP_W'(RAS_DEPTH));
    assign do_pop    = counterLd & ret;
    assign do_push   = counterLd & jmp & call & ~ret;

    // Redirect selection; the address goes straight to memory so redirects cost no bubble.
    always_comb begin
        next_pc = linkAddr;
        if (ret) begin
            next_pc = ras_empty ? RESET_PC : ras_mem[top];
        end else if (jmp) begin
            next_pc = jmpTarget;
        end else if (pcSrc) begin
            next_pc = br_target;
        end
        imemAddr = counterRst ? RESET_PC : (counterLd ? next_pc : pc);
    end

    always_ff @(posedge clk) begin
        if (counterRst) begin
            pc           <= RESET_PC;
            instValid    <= 1'b0;
            rasDepth     <= '0;
            top          <= '0;
            rasOverflow  <= 1'b0;
            rasUnderflow <= 1'b0;
        end else begin
            pc <= imemAddr;
            if (counterLd) begin
                instValid <= 1'b1;
            end
            if (do_pop) begin
                if (ras_empty) begin
                    rasUnderflow <= 1'b1;
                end else begin
                    top      <= top - SP_W'(1);
                    rasDepth <= rasDepth - DEP_W'(1);
                end
            end else if (do_push) begin
                // When full the pointer still advances, overwriting the oldest entry.
                top <= top + SP_W'(1);
                if (ras_full) begin
                    rasOverflow <= 1'b1;
                end else begin
                    rasDepth <= rasDepth + DEP_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!counterRst && do_push) begin
            ras_mem[top + SP_W'(1)] <= linkAddr;
        end
    end

endmodule
